// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sa_pkg
// Description : Shared types, sizes and helpers for the self-attention
//               phase scheduler (sa_sched) and its loop counter.
// Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

    // Scheduler phase, also driven out on the phase port
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        QKV   = 3'd2,
        QK    = 3'd3,
        SCL   = 3'd4,
        ACC   = 3'd5,
        DRAIN = 3'd6
    } phase_e;

    localparam int LOAD_LEN = 192;   // X bytes + three weight matrices
    localparam int DIM      = 8;     // MAC lanes / matrix dimension
    localparam int W_BYTES  = 64;    // bytes per 8x8 weight matrix

    // Sequence length clamp: 0 -> 1, above DIM -> DIM
    function automatic logic [3:0] clamp_t(input logic [3:0] t);
        if (t == 4'd0) begin
            return 4'd1;
        end else if (t > 4'(DIM)) begin
            return 4'(DIM);
        end else begin
            return t;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : sa_sched_if
// Description : Handshake/control bundle of the SA phase scheduler.
//               perf_cyc exists only when SA_SCHED_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface sa_sched_if;

    logic        in_valid;
    logic [3:0]  T;
    logic        busy;
    logic [2:0]  phase;
    logic [3:0]  t_len;
    logic        ld_x_en;
    logic        ld_w_en;
    logic [1:0]  ld_sel;
    logic [5:0]  ld_addr;
    logic [1:0]  mat_sel;
    logic [2:0]  row;
    logic [2:0]  kidx;
    logic        acc_clr;
    logic        acc_wr;
    logic        out_valid;
    logic [5:0]  out_idx;
`ifdef SA_SCHED_PERF_EN
    logic [10:0] perf_cyc;
`endif

    // Job source side (drives the load strobe, observes control)
    modport master (
        output in_valid, T,
        input  busy, phase, t_len, ld_x_en, ld_w_en, ld_sel, ld_addr,
               mat_sel, row, kidx, acc_clr, acc_wr, out_valid, out_idx
`ifdef SA_SCHED_PERF_EN
        , input perf_cyc
`endif
    );

    // Scheduler side
    modport slave (
        input  in_valid, T,
        output busy, phase, t_len, ld_x_en, ld_w_en, ld_sel, ld_addr,
               mat_sel, row, kidx, acc_clr, acc_wr, out_valid, out_idx
`ifdef SA_SCHED_PERF_EN
        , output perf_cyc
`endif
    );

endinterface
`default_nettype wire

// File: rtl/sa_loop_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sa_loop_cnt
// Description : Three-level nested counter (outer/mid/inner) with
//               programmable last values, a clearing start pulse and a
//               wrap flag raised on the final count of the nest.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_loop_cnt (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_start,
    input  wire logic       i_en,
    input  wire logic [1:0] i_outer_last,
    input  wire logic [2:0] i_mid_last,
    input  wire logic [2:0] i_inner_last,
    output logic      [1:0] o_outer,
    output logic      [2:0] o_mid,
    output logic      [2:0] o_inner,
    output logic            o_wrap
);

    logic [1:0] r_outer;
    logic [2:0] r_mid;
    logic [2:0] r_inner;
    logic       w_inner_end;
    logic       w_mid_end;
    logic       w_outer_end;

    assign w_inner_end = (r_inner == i_inner_last);
    assign w_mid_end   = (r_mid   == i_mid_last);
    assign w_outer_end = (r_outer == i_outer_last);

    assign o_outer = r_outer;
    assign o_mid   = r_mid;
    assign o_inner = r_inner;
    assign o_wrap  = w_inner_end & w_mid_end & w_outer_end;

    // Start clears the nest (and wins over a wrap), otherwise ripple-carry advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outer <= '0;
            r_mid   <= '0;
            r_inner <= '0;
        end else if (i_start) begin
            r_outer <= '0;
            r_mid   <= '0;
            r_inner <= '0;
        end else if (i_en) begin
            if (!w_inner_end) begin
                r_inner <= r_inner + 3'd1;
            end else begin
                r_inner <= '0;
                if (!w_mid_end) begin
                    r_mid <= r_mid + 3'd1;
                end else begin
                    r_mid <= '0;
                    if (!w_outer_end) begin
                        r_outer <= r_outer + 2'd1;
                    end else begin
                        r_outer <= '0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sa_sched.sv
`default_nettype none
// ============================================================================
// Module      : sa_sched
// Description : Phase scheduler for the self-attention datapath. Samples the
//               192-cycle load burst, then sequences QKV, QK^T, ReLU/3 scale,
//               score x V accumulation and the result drain. Control only.
//               Optional: SA_SCHED_PERF_EN adds the perf_cyc counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_sched
    import sa_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst_n,
    sa_sched_if.slave  bus
);

    localparam logic [1:0] c_load_outer_last = 2'(LOAD_LEN / W_BYTES - 1);
    localparam logic [1:0] c_qkv_outer_last  = 2'd2;
    localparam logic [2:0] c_dim_last        = 3'(DIM - 1);

    phase_e     r_state;
    logic [3:0] r_t_len;

    logic [1:0] w_outer;
    logic [2:0] w_mid;
    logic [2:0] w_inner;
    logic       w_wrap;
    logic       w_start;
    logic       w_busy;
    logic [2:0] w_tm1;
    logic [1:0] w_outer_last;
    logic [2:0] w_mid_last;
    logic [2:0] w_inner_last;

    assign w_busy  = (r_state != IDLE);
    assign w_tm1   = 3'(r_t_len - 4'd1);
    // The counter is held clear in IDLE and restarted at every phase boundary
    assign w_start = (r_state == IDLE) || w_wrap;

    // Loop limits for the counter, chosen by the current phase
    always_comb begin
        w_outer_last = '0;
        w_mid_last   = '0;
        w_inner_last = '0;
        case (r_state)
            LOAD: begin
                w_outer_last = c_load_outer_last;
                w_mid_last   = c_dim_last;
                w_inner_last = c_dim_last;
            end
            QKV: begin
                w_outer_last = c_qkv_outer_last;
                w_mid_last   = w_tm1;
                w_inner_last = c_dim_last;
            end
            QK, DRAIN: begin
                w_mid_last   = w_tm1;
                w_inner_last = c_dim_last;
            end
            SCL: begin
                w_mid_last   = w_tm1;
            end
            ACC: begin
                w_mid_last   = w_tm1;
                w_inner_last = w_tm1;
            end
            default: begin
            end
        endcase
    end

    sa_loop_cnt u_loop_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (w_start),
        .i_en         (w_busy),
        .i_outer_last (w_outer_last),
        .i_mid_last   (w_mid_last),
        .i_inner_last (w_inner_last),
        .o_outer      (w_outer),
        .o_mid        (w_mid),
        .o_inner      (w_inner),
        .o_wrap       (w_wrap)
    );

    // Phase sequencing; t_len is latched on job start and cleared on return to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_t_len <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_t_len <= clamp_t(bus.T);
                        r_state <= LOAD;
                    end
                end
                LOAD:  if (w_wrap) r_state <= QKV;
                QKV:   if (w_wrap) r_state <= QK;
                QK:    if (w_wrap) r_state <= SCL;
                SCL:   if (w_wrap) r_state <= ACC;
                ACC:   if (w_wrap) r_state <= DRAIN;
                DRAIN: begin
                    if (w_wrap) begin
                        r_state <= IDLE;
                        r_t_len <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_t_len <= '0;
                end
            endcase
        end
    end

    logic       w_ld_x_en;
    logic       w_ld_w_en;
    logic [1:0] w_ld_sel;
    logic [5:0] w_ld_addr;
    logic [1:0] w_mat_sel;
    logic [2:0] w_row;
    logic [2:0] w_kidx;
    logic       w_acc_clr;
    logic       w_acc_wr;
    logic       w_out_valid;
    logic [5:0] w_out_idx;

    // Moore decode of the datapath controls from state and counter registers
    always_comb begin
        w_ld_x_en   = 1'b0;
        w_ld_w_en   = 1'b0;
        w_ld_sel    = '0;
        w_ld_addr   = '0;
        w_mat_sel   = '0;
        w_row       = '0;
        w_kidx      = '0;
        w_acc_clr   = 1'b0;
        w_acc_wr    = 1'b0;
        w_out_valid = 1'b0;
        w_out_idx   = '0;
        case (r_state)
            LOAD: begin
                w_ld_w_en = 1'b1;
                w_ld_sel  = w_outer;
                w_ld_addr = {w_mid, w_inner};
                w_ld_x_en = ({w_outer, w_mid, w_inner} < {1'b0, r_t_len, 3'b000});
            end
            QKV, QK: begin
                w_mat_sel = (r_state == QKV) ? w_outer : 2'd0;
                w_row     = w_mid;
                w_kidx    = w_inner;
                w_acc_clr = (w_inner == 3'd0);
                w_acc_wr  = (w_inner == c_dim_last);
            end
            SCL: begin
                w_row    = w_mid;
                w_acc_wr = 1'b1;
            end
            ACC: begin
                w_row     = w_mid;
                w_kidx    = w_inner;
                w_acc_clr = (w_inner == 3'd0);
                w_acc_wr  = (w_inner == w_tm1);
            end
            DRAIN: begin
                w_out_valid = 1'b1;
                w_out_idx   = {w_mid, w_inner};
            end
            default: begin
            end
        endcase
    end

    assign bus.busy      = w_busy;
    assign bus.phase     = r_state;
    assign bus.t_len     = r_t_len;
    assign bus.ld_x_en   = w_ld_x_en;
    assign bus.ld_w_en   = w_ld_w_en;
    assign bus.ld_sel    = w_ld_sel;
    assign bus.ld_addr   = w_ld_addr;
    assign bus.mat_sel   = w_mat_sel;
    assign bus.row       = w_row;
    assign bus.kidx      = w_kidx;
    assign bus.acc_clr   = w_acc_clr;
    assign bus.acc_wr    = w_acc_wr;
    assign bus.out_valid = w_out_valid;
    assign bus.out_idx   = w_out_idx;

`ifdef SA_SCHED_PERF_EN
    logic [10:0] r_perf_cyc;

    // Compute-phase cycle count: cleared on job start, held after DRAIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cyc <= '0;
        end else if ((r_state == IDLE) && bus.in_valid) begin
            r_perf_cyc <= '0;
        end else if (r_state >= QKV && r_state <= DRAIN) begin
            r_perf_cyc <= r_perf_cyc + 11'd1;
        end
    end

    assign bus.perf_cyc = r_perf_cyc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sa_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_sched
// Description : Self-checking bench for sa_sched. A cycle-indexed reference
//               model derives every control output from the phase lengths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_sched;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sa_sched_if bus ();

    sa_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack every observable output into one word
    function automatic logic [63:0] obs_vec();
        logic [63:0] v;
        v = '0;
        v[34:0] = {bus.busy, bus.phase, bus.t_len, bus.ld_x_en, bus.ld_w_en,
                   bus.ld_sel, bus.ld_addr, bus.mat_sel, bus.row, bus.kidx,
                   bus.acc_clr, bus.acc_wr, bus.out_valid, bus.out_idx};
`ifdef SA_SCHED_PERF_EN
        v[45:35] = bus.perf_cyc;
`endif
        return v;
    endfunction

    // Reference: expected outputs at cycle k of a job with clamped length t
    function automatic logic [63:0] model_vec(input int t, input int k);
        int busy, ph, ldx, ldw, sel, addr, mat, row, kidx, clr, wr, ov, oidx, perf, tl, r, n;
        logic [63:0] v;
        busy = 0; ph = 0; ldx = 0; ldw = 0; sel = 0; addr = 0; mat = 0; row = 0;
        kidx = 0; clr = 0; wr = 0; ov = 0; oidx = 0; tl = 0;
        n    = 192 + 33 * t + t * t + 8 * t;
        perf = (k <= 192) ? 0 : ((k < n) ? k - 192 : n - 192);
        if (k < n) begin
            busy = 1;
            tl   = t;
            if (k < 192) begin
                ph = 1; ldw = 1; sel = k / 64; addr = k % 64; ldx = (k < 8 * t) ? 1 : 0;
            end else begin
                r = k - 192;
                if (r < 24 * t) begin
                    ph = 2; mat = r / (8 * t); row = (r % (8 * t)) / 8; kidx = r % 8;
                    clr = (kidx == 0) ? 1 : 0; wr = (kidx == 7) ? 1 : 0;
                end else if (r < 32 * t) begin
                    r = r - 24 * t;
                    ph = 3; row = r / 8; kidx = r % 8;
                    clr = (kidx == 0) ? 1 : 0; wr = (kidx == 7) ? 1 : 0;
                end else if (r < 33 * t) begin
                    ph = 4; row = r - 32 * t; wr = 1;
                end else if (r < 33 * t + t * t) begin
                    r = r - 33 * t;
                    ph = 5; row = r / t; kidx = r % t;
                    clr = (kidx == 0) ? 1 : 0; wr = (kidx == t - 1) ? 1 : 0;
                end else begin
                    ph = 6; ov = 1; oidx = r - 33 * t - t * t;
                end
            end
        end
        v = '0;
        v[34:0] = {busy[0], ph[2:0], tl[3:0], ldx[0], ldw[0], sel[1:0], addr[5:0],
                   mat[1:0], row[2:0], kidx[2:0], clr[0], wr[0], ov[0], oidx[5:0]};
`ifdef SA_SCHED_PERF_EN
        v[45:35] = perf[10:0];
`endif
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One job: raise in_valid with T, compare every cycle against the model.
    // hold keeps in_valid high through DRAIN; stop_at >= 0 abandons the job there.
    task automatic run_job(input int tin, input bit hold, input int stop_at, output int first_ov);
        int t, n, nov;
        bit stopped;
        t        = (tin == 0) ? 1 : ((tin > 8) ? 8 : tin);
        n        = 192 + 41 * t + t * t;
        first_ov = -1;
        nov      = 0;
        stopped  = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.T        = 4'(tin);
        for (int k = 0; k <= n; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("vec_T%0d_c%0d", tin, k), obs_vec(), model_vec(t, k));
            if (bus.out_valid === 1'b1) begin
                if (first_ov < 0) first_ov = k;
                nov++;
            end
            if (k == stop_at) begin
                stopped = 1'b1;
                break;
            end
            @(negedge clk);
            bus.T = 4'($urandom_range(0, 15));
            if (!hold || k == n) bus.in_valid = 1'b0;
        end
        if (!stopped) begin
            check($sformatf("first_ov_T%0d", tin), 64'(first_ov), 64'(192 + 33 * t + t * t));
            check($sformatf("nov_T%0d", tin), 64'(nov), 64'(8 * t));
            @(posedge clk);
            #1;
            check($sformatf("idle_after_T%0d", tin), 64'(bus.busy), 64'd0);
        end
    endtask

    int lat;

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.T        = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", obs_vec(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_valid", obs_vec(), 64'd0);

        // Reset mid-QK of a T=4 job clears everything at once
        run_job(4, 1'b0, 192 + 24 * 4 + 5, lat);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_midqk", obs_vec(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(1, 1'b0, -1, lat);
        check("latency_T1", 64'(lat), 64'd226);
        run_job(8, 1'b0, -1, lat);
        check("latency_T8", 64'(lat), 64'd520);
        run_job(4, 1'b0, -1, lat);
        check("latency_T4", 64'(lat), 64'd340);
        run_job(0, 1'b0, -1, lat);
        check("latency_T0", 64'(lat), 64'd226);
        run_job(12, 1'b0, -1, lat);
        check("latency_T12", 64'(lat), 64'd520);

        // in_valid held through the whole job must not restart it
        run_job(2, 1'b1, -1, lat);
        repeat (3) @(posedge clk);
        #1;
        check("hold_no_restart", obs_vec(), model_vec(2, 192 + 82 + 4 + 4));

        for (int j = 0; j < 3; j++) begin
            run_job(int'($urandom_range(0, 15)), 1'(j == 1), -1, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
